mem_xfer_ctrl: RTL and testbench

Sequencing FSM for the memory-to-memory transfer path. Each accepted word is read from memory A and written into memory B. The block drives the increment and clear strobes of the source (A) and destination (B) address counters, captures the source read data, and presents it with a write enable to memory B. It sits between the top-level start/done interface and the two address counters.

---
 rtl/mem_xfer_ctrl_if.sv | 40 ++++
 rtl/mem_xfer_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_xfer_ctrl_if.sv
// Start/done, memory A/B data and address-counter strobes of the transfer controller.
// Optional MEM_XFER_CHKSUM_EN adds the chksum signal to both modports.
interface mem_xfer_ctrl_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic          start;
    logic [AW:0]   xfer_len;
    logic [DW-1:0] dataA;
    logic          dst_ready;
    logic          IncA;
    logic          IncB;
    logic          ClrAB;
    logic          WEB;
    logic [DW-1:0] dataB;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;
`ifdef MEM_XFER_CHKSUM_EN
    logic [DW-1:0] chksum;

    modport slave (
        input  start, xfer_len, dataA, dst_ready,
        output IncA, IncB, ClrAB, WEB, dataB, busy, done, dbg_state, chksum
    );
    modport master (
        output start, xfer_len, dataA, dst_ready,
        input  IncA, IncB, ClrAB, WEB, dataB, busy, done, dbg_state, chksum
    );
`else
    modport slave (
        input  start, xfer_len, dataA, dst_ready,
        output IncA, IncB, ClrAB, WEB, dataB, busy, done, dbg_state
    );
    modport master (
        output start, xfer_len, dataA, dst_ready,
        input  IncA, IncB, ClrAB, WEB, dataB, busy, done, dbg_state
    );
`endif
endinterface

// File: rtl/mem_xfer_ctrl.sv
// Memory A -> memory B word-copy sequencer driving the two address counters.
// Optional running XOR checksum output is enabled with MEM_XFER_CHKSUM_EN.
module mem_xfer_ctrl #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_xfer_ctrl_if.slave  bus
);
    // Handshake: a write to memory B completes in any cycle where WEB and
    // dst_ready are both high; WEB and dataB hold until that happens.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [AW:0] MAX_LEN = (AW+1)'(2**AW);

    state_t        r_state;
    state_t        w_next;
    logic [AW:0]   r_len;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_data;

    logic          w_inc;
    logic          w_clr;
    logic          w_web;
    logic          w_done;
    logic          w_busy;
    logic          w_last;
    logic          w_accept;
    logic          w_start;
    logic [AW:0]   w_len_sat;

    assign w_start   = (r_state == S_IDLE) && bus.start;
    assign w_len_sat = (bus.xfer_len > MAX_LEN) ? MAX_LEN : bus.xfer_len;
    assign w_last    = (r_cnt == (r_len - (AW+1)'(1)));
    assign w_accept  = (r_state == S_WR) && bus.dst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        w_clr  = 1'b0;
        w_web  = 1'b0;
        w_done = 1'b0;
        w_busy = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.xfer_len == '0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                w_clr  = 1'b1;
                w_next = S_RD;
            end
            S_RD:  w_next = S_CAP;
            S_CAP: w_next = S_WR;
            S_WR: begin
                w_web = 1'b1;
                if (bus.dst_ready) begin
                    w_inc  = 1'b1;
                    w_next = w_last ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            if (w_start) begin
                r_len <= w_len_sat;
            end
            if (r_state == S_CLR) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + (AW+1)'(1);
            end
            if (r_state == S_CAP) begin
                r_data <= bus.dataA;
            end
        end
    end

`ifdef MEM_XFER_CHKSUM_EN
    logic [DW-1:0] r_chk;

    // A zero-length transfer never visits CLR, so it clears on its start instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk <= '0;
        end else if ((r_state == S_CLR) || (w_start && (bus.xfer_len == '0))) begin
            r_chk <= '0;
        end else if (w_accept) begin
            r_chk <= r_chk ^ r_data;
        end
    end

    assign bus.chksum = r_chk;
`endif

    assign bus.IncA      = w_inc;
    assign bus.IncB      = w_inc;
    assign bus.ClrAB     = w_clr;
    assign bus.WEB       = w_web;
    assign bus.done      = w_done;
    assign bus.busy      = w_busy;
    assign bus.dataB     = r_data;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl with modelled address counters and memories.
module tb_mem_xfer_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst;

  mem_xfer_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_xfer_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // environment: address counters, synchronous-read memory A, memory B
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ClrAB) addr_a <= '0;
    else if (bus.IncA) addr_a <= addr_a + 1'b1;
    if (bus.ClrAB) addr_b <= '0;
    else if (bus.IncB) addr_b <= addr_b + 1'b1;
    bus.dataA <= mem_a[addr_a];
    if (bus.WEB && bus.dst_ready) mem_b[addr_b] <= bus.dataB;
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_chk;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // dst_ready driver: forced stalls first, then optional random stalls
  int stall_total = 0;
  int bp_target   = 0;
  bit rnd_bp      = 1'b0;

  initial begin
    bus.dst_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.WEB && (stall_total < bp_target)) begin
        bus.dst_ready = 1'b0;
        stall_total++;
      end else if (rnd_bp) begin
        bus.dst_ready = ($urandom_range(0, 3) != 0);
        if (bus.WEB && !bus.dst_ready) stall_total++;
      end else begin
        bus.dst_ready = 1'b1;
      end
    end
  end

  // monitor
  int wr_total   = 0;
  int inc_total  = 0;
  int clr_total  = 0;
  int done_total = 0;
  int done_cyc   = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.IncA || bus.IncB) begin
          check("inc_pair", bus.IncA, bus.IncB);
          check("inc_vs_clr", bus.ClrAB, 0);
          inc_total++;
        end
        if (bus.ClrAB) clr_total++;
        if (bus.WEB) begin
          check("inc_on_accept", bus.IncA, bus.dst_ready);
          if (bus.dst_ready) begin
            if (exp_q.size() == 0) check("extra_wr", bus.WEB, 0);
            else check("wr_data", bus.dataB, exp_q.pop_front());
            wr_total++;
          end else if (exp_q.size() > 0) begin
            check("wr_hold", bus.dataB, exp_q[0]);
          end
        end
        if (bus.done) begin
          done_total++;
          done_cyc = cyc;
`ifdef MEM_XFER_CHKSUM_EN
          check("chksum", bus.chksum, exp_chk);
`endif
        end
      end
    end
  end

  task automatic run_xfer(input int len, input int bp, input bit rnd, input bit poke, input bit fixed);
    int eff;
    int s_cyc, wr_b, inc_b, clr_b, done_b, stall_b, exp_lat;
    eff = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < DEPTH; i++)
      mem_a[i] = fixed ? DW'(8'h11 * (i + 1)) : DW'($urandom);
    exp_q.delete();
    exp_chk = '0;
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back(mem_a[i]);
      exp_chk = exp_chk ^ mem_a[i];
    end
    wr_b = wr_total; inc_b = inc_total; clr_b = clr_total;
    done_b = done_total; stall_b = stall_total;
    bp_target = stall_total + bp;
    rnd_bp = rnd;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.xfer_len = (AW+1)'(len);
    s_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.xfer_len = (AW+1)'($urandom_range(0, 15));
    if (poke) begin
      repeat (4) @(posedge clk);
      #1 bus.start = 1'b1;
      bus.xfer_len = (AW+1)'($urandom_range(1, 15));
      @(posedge clk); #1 bus.start = 1'b0;
    end
    for (int k = 0; k < 400 && done_total == done_b; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    rnd_bp = 1'b0;
    exp_lat = (eff == 0) ? 1 : 2 + 3 * eff + (stall_total - stall_b);
    check($sformatf("done_cnt_len%0d", len), done_total - done_b, 1);
    check($sformatf("latency_len%0d", len), done_cyc - s_cyc, exp_lat);
    check($sformatf("writes_len%0d", len), wr_total - wr_b, eff);
    check($sformatf("incs_len%0d", len), inc_total - inc_b, eff);
    check($sformatf("clrs_len%0d", len), clr_total - clr_b, (eff > 0) ? 1 : 0);
    check("idle_after", bus.busy, 0);
    check("exp_q_drained", exp_q.size(), 0);
    for (int i = 0; i < eff; i++) check($sformatf("mem_b[%0d]", i), mem_b[i], mem_a[i]);
  endtask

  initial begin
    int wr_b, done_b;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.xfer_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_dataB", bus.dataB, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", {bus.busy, bus.done, bus.WEB, bus.IncA, bus.IncB, bus.ClrAB}, 0);
    end

    run_xfer(3, 0, 1'b0, 1'b0, 1'b1);   // basic copy 0x11,0x22,0x33
    run_xfer(2, 4, 1'b0, 1'b0, 1'b0);   // four stall cycles in first WR
    run_xfer(0, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(8, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(15, 0, 1'b0, 1'b0, 1'b0);  // saturates to 8
    run_xfer(4, 0, 1'b0, 1'b1, 1'b0);   // start pulsed while busy

    // reset one cycle after the second write of a len=5 transfer
    for (int i = 0; i < DEPTH; i++) mem_a[i] = DW'($urandom);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(mem_a[i]);
    wr_b = wr_total; done_b = done_total;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.xfer_len = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 100 && (wr_total - wr_b) < 2; k++) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_mid_busy", bus.busy, 0);
    repeat (15) @(posedge clk);
    #1;
    check("rst_mid_done", done_total - done_b, 0);
    check("rst_mid_writes", wr_total - wr_b, 2);
    run_xfer(1, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 16; t++)
      run_xfer($urandom_range(0, 15), $urandom_range(0, 3), 1'b1, 1'(t % 3 == 0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
